// File: rtl/l0_feed_ctrl_pkg.sv
// l0_feed_ctrl_pkg
//   Shared definitions for the L0 feed sequencer: FSM state encoding and the
//   default geometry constants that the L0 buffer and MAC array also build from.
package l0_feed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int L0_ROW      = 8;   // L0 rows = MAC array rows
  localparam int L0_DEPTH    = 64;  // L0 FIFO depth, maximum legal transfer length
  localparam int SRAM_ADDR_W = 11;  // activation SRAM address width
  localparam int L0_LEN_W    = 7;   // transfer length width, 2**L0_LEN_W > L0_DEPTH

endpackage

// File: rtl/l0_feed_ctrl_rd_skew.sv
// l0_rd_skew
//   Row-bit shift register that turns a single issue stream into per-row L0
//   read enables, each row delayed one cycle relative to the row above it.
//   Ports:
//     i_clk    clock
//     i_reset  asynchronous active-high clear
//     i_issue  read issue bit for row 0 (takes effect on the next cycle)
//     o_l0_rd  per-row L0 read enables
module l0_rd_skew #(
  parameter int ROW = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_issue,
  output logic [ROW-1:0] o_l0_rd
);

  logic [ROW-1:0] r_rd;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd <= '0;
    end else begin
      r_rd <= {r_rd[ROW-2:0], i_issue};
    end
  end

  assign o_l0_rd = r_rd;

endmodule

// File: rtl/l0_feed_ctrl.sv
// l0_feed_ctrl
//   Sequencer in front of the L0 activation buffer. A start in IDLE loads LEN
//   words from the activation SRAM into L0 (SRAM Q feeds L0 directly, so the
//   L0 write strobe trails the SRAM read by one cycle), then drains L0 into the
//   MAC array with per-row read enables skewed one cycle per row.
//   Ports:
//     i_clk, i_reset       clock, asynchronous active-high reset
//     i_start              start pulse, honoured only in IDLE
//     i_base_addr, i_len   first SRAM address and word count, latched with start
//     o_sram_cen/wen/addr  SRAM read port (active-low enables, wen tied high)
//     o_l0_wr              L0 write strobe
//     o_l0_rd              per-row L0 read enables
//     i_l0_full/empty      per-row L0 status flags
//     o_busy, o_done       activity flag, end-of-transfer pulse
//     o_err                sticky error (length, overflow, underflow)
module l0_feed_ctrl
  import l0_feed_ctrl_pkg::*;
#(
  parameter int ROW    = L0_ROW,
  parameter int DEPTH  = L0_DEPTH,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int LEN_W  = L0_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_l0_wr,
  output logic [ROW-1:0]    o_l0_rd,
  input  logic [ROW-1:0]    i_l0_full,
  input  logic [ROW-1:0]    i_l0_empty,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  // One extra bit so len+row-2 never overflows the cycle counter.
  localparam int CNT_W = LEN_W + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_cen;
  logic              w_cen_nxt;
  logic              r_wr;
  logic              w_wr_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_issue;
  logic              w_start_ok;
  logic [CNT_W-1:0]  w_len_ext;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_load_last;
  logic              w_drain_last;
  logic [ROW-1:0]    w_l0_rd;

  assign w_start_ok   = (r_state == ST_IDLE) && i_start;
  assign w_len_ext    = {1'b0, r_len};
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_load_last  = (r_cnt == w_len_ext);
  assign w_drain_last = (r_cnt == w_len_ext + CNT_W'(ROW - 2));

  // State register: r_cnt is the cycle index within LOAD/DRAIN.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start_ok) begin
        r_len <= i_len;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (i_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_load_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_DRAIN: begin
        if (w_drain_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: values the registered outputs take on the next cycle.
  // Issue is evaluated one cycle ahead so that row 0 reads on DRAIN cycles
  // 0..len-1 once it passes through the skew register.
  always_comb begin
    w_cen_nxt  = 1'b1;
    w_addr_nxt = '0;
    w_wr_nxt   = 1'b0;
    w_issue    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && (i_len != '0)) begin
          w_cen_nxt  = 1'b0;
          w_addr_nxt = i_base_addr;
        end
      end
      ST_LOAD: begin
        // Each SRAM read this cycle lands in L0 next cycle.
        w_wr_nxt = ~r_cen;
        if (w_cnt_inc < w_len_ext) begin
          w_cen_nxt  = 1'b0;
          w_addr_nxt = r_addr + ADDR_W'(1);
        end
        if (w_load_last) begin
          w_issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_issue = (w_cnt_inc < w_len_ext);
      end
      default: begin
      end
    endcase

    w_err_nxt = r_err;
    if (w_start_ok) begin
      w_err_nxt = ({1'b0, i_len} > CNT_W'(DEPTH));
    end else if ((r_wr && (|i_l0_full)) || (|(w_l0_rd & i_l0_empty))) begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cen  <= 1'b1;
      r_addr <= '0;
      r_wr   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cen  <= w_cen_nxt;
      r_addr <= w_addr_nxt;
      r_wr   <= w_wr_nxt;
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE);
      r_err  <= w_err_nxt;
    end
  end

  l0_rd_skew #(
    .ROW (ROW)
  ) u_rd_skew (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_issue (w_issue),
    .o_l0_rd (w_l0_rd)
  );

  assign o_sram_cen  = r_cen;
  assign o_sram_wen  = 1'b1;
  assign o_sram_addr = r_addr;
  assign o_l0_wr     = r_wr;
  assign o_l0_rd     = w_l0_rd;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_l0_feed_ctrl.sv
`timescale 1ns/1ps
module tb_l0_feed_ctrl;

  localparam int ROW   = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 11;
  localparam int LW    = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic [ROW-1:0] full;
  logic [ROW-1:0] empty;
  logic          cen;
  logic          wen;
  logic [AW-1:0] addr;
  logic          wr;
  logic [ROW-1:0] rd;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  l0_feed_ctrl dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_base_addr (base),
    .i_len       (len),
    .o_sram_cen  (cen),
    .o_sram_wen  (wen),
    .o_sram_addr (addr),
    .o_l0_wr     (wr),
    .o_l0_rd     (rd),
    .i_l0_full   (full),
    .i_l0_empty  (empty),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a transfer is an offset o counted from the first busy
  // cycle; every output is a closed-form function of o, len and base.
  bit m_active = 1'b0;
  int m_o      = 0;
  int m_len    = 0;
  int m_base   = 0;
  bit m_err    = 1'b0;
  logic          e_cen;
  logic [AW-1:0] e_addr;
  logic          e_wr;
  logic [ROW-1:0] e_rd;
  logic          e_busy;
  logic          e_done;

  // Attached L0 occupancy model, used for the full-length transfer.
  bit use_l0 = 1'b0;
  int l0_cnt[ROW];
  int l0_rds[ROW];

  function automatic int last_off(int l);
    return (l == 0) ? 0 : 2 * l + ROW;
  endfunction

  function automatic void model_outputs();
    int d;
    e_cen = 1'b1; e_addr = '0; e_wr = 1'b0; e_rd = '0; e_busy = 1'b0; e_done = 1'b0;
    if (m_active) begin
      e_busy = 1'b1;
      e_done = (m_o == last_off(m_len));
      if (m_len != 0) begin
        if (m_o < m_len) begin
          e_cen  = 1'b0;
          e_addr = AW'((m_base + m_o) % (1 << AW));
        end
        e_wr = (m_o >= 1) && (m_o <= m_len);
        d = m_o - (m_len + 1);
        for (int i = 0; i < ROW; i++) e_rd[i] = (d >= i) && (d <= i + m_len - 1);
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    model_outputs();
    chk("sram_cen",  32'(cen),  32'(e_cen));
    chk("sram_wen",  32'(wen),  32'd1);
    chk("sram_addr", 32'(addr), 32'(e_addr));
    chk("l0_wr",     32'(wr),   32'(e_wr));
    chk("l0_rd",     32'(rd),   32'(e_rd));
    chk("busy",      32'(busy), 32'(e_busy));
    chk("done",      32'(done), 32'(e_done));
    chk("err",       32'(err),  32'(m_err));
  endtask

  task automatic drive_l0_flags();
    for (int i = 0; i < ROW; i++) begin
      full[i]  = (l0_cnt[i] >= DEPTH);
      empty[i] = (l0_cnt[i] == 0);
    end
  endtask

  // One clock: the model advances on the edge using this cycle's inputs,
  // the DUT is checked at the following falling edge.
  task automatic step();
    @(posedge clk);
    model_outputs();
    if (!rst) begin
      if (!m_active && start) m_err = (int'(len) > DEPTH);
      else if ((e_wr && (|full)) || (|(e_rd & empty))) m_err = 1'b1;
      if (use_l0) begin
        for (int i = 0; i < ROW; i++) begin
          l0_cnt[i] += int'(e_wr) - int'(e_rd[i]);
          l0_rds[i] += int'(e_rd[i]);
        end
      end
      if (m_active) begin
        m_o++;
        if (m_o > last_off(m_len)) m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1;
        m_o      = 0;
        m_len    = int'(len);
        m_base   = int'(base);
      end
    end
    @(negedge clk);
    if (use_l0) drive_l0_flags();
    compare_all();
  endtask

  task automatic launch(input int b, input int l);
    start = 1'b1;
    base  = AW'(b);
    len   = LW'(l);
    step();
    start = 1'b0;
    base  = AW'($urandom);
    len   = LW'($urandom);
  endtask

  task automatic run_idle(input int bound);
    int t;
    t = 0;
    while ((busy || m_active) && t < bound) begin
      step();
      t++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    start = 1'b0;
    #1;
    chk("rst_cen",  32'(cen),  32'd1);
    chk("rst_wen",  32'(wen),  32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wr",   32'(wr),   32'd0);
    chk("rst_rd",   32'(rd),   32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    m_active = 1'b0;
    m_err    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  int busy_n, wr_n, cen_n, r0, r7, t;
  logic [AW-1:0] seen [4];

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; full = '0; empty = '0;
    for (int i = 0; i < ROW; i++) begin l0_cnt[i] = 0; l0_rds[i] = 0; end
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // Basic transfer base 0x010, len 4.
    launch(12'h010, 4);
    chk("t1_first_addr", 32'(addr), 32'h010);
    chk("t1_first_cen",  32'(cen),  32'd0);
    busy_n = 1; wr_n = 0; cen_n = 1; r0 = -1; r7 = -1; t = 0;
    while (busy && t < 100) begin
      step();
      t++;
      if (busy) busy_n++;
      if (wr) wr_n++;
      if (!cen) cen_n++;
      if (rd[0] && r0 < 0) r0 = t;
      if (rd[7] && r7 < 0) r7 = t;
    end
    chk("t1_busy_cycles", 32'(busy_n), 32'd17);
    chk("t1_wr_cycles",   32'(wr_n),   32'd4);
    chk("t1_cen_cycles",  32'(cen_n),  32'd4);
    chk("t1_rd0_rise",    32'(r0),     32'd5);
    chk("t1_rd7_skew",    32'(r7 - r0), 32'd7);

    // Zero length: straight to DONE.
    step();
    launch(12'h123, 0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    step();
    chk("t2_done_end", 32'(done), 32'd0);
    chk("t2_err",      32'(err),  32'd0);

    // Address wrap.
    step();
    launch(12'h7FE, 4);
    seen[0] = addr;
    for (int k = 1; k < 4; k++) begin step(); seen[k] = addr; end
    chk("t3_addr0", 32'(seen[0]), 32'h7FE);
    chk("t3_addr1", 32'(seen[1]), 32'h7FF);
    chk("t3_addr2", 32'(seen[2]), 32'h000);
    chk("t3_addr3", 32'(seen[3]), 32'h001);
    run_idle(100);

    // Reset in the middle of DRAIN, then a clean transfer.
    launch(12'h100, 5);
    for (int k = 0; k < 8; k++) step();
    async_reset();
    step();
    launch(12'h200, 3);
    run_idle(100);

    // Start ignored while busy; overflow during LOAD sets err; next start clears.
    launch(12'h040, 6);
    step();
    start = 1'b1; len = LW'(2);
    step();
    start = 1'b0;
    full = '1;
    step();
    step();
    full = '0;
    step();
    chk("t5_err_set", 32'(err), 32'd1);
    run_idle(100);
    chk("t5_err_sticky", 32'(err), 32'd1);
    launch(12'h000, 2);
    chk("t5_err_cleared", 32'(err), 32'd0);
    run_idle(100);

    // Length beyond depth flags err at once.
    launch(12'h050, 70);
    chk("t_len_err", 32'(err), 32'd1);
    run_idle(300);

    // Full-depth transfer into an attached L0 model.
    use_l0 = 1'b1;
    for (int i = 0; i < ROW; i++) begin l0_cnt[i] = 0; l0_rds[i] = 0; end
    drive_l0_flags();
    step();
    launch(12'h300, 64);
    run_idle(400);
    chk("t6_err", 32'(err), 32'd0);
    for (int i = 0; i < ROW; i++) chk("t6_row_reads", 32'(l0_rds[i]), 32'd64);
    use_l0 = 1'b0;
    full = '0; empty = '0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1;
        base  = AW'($urandom);
        len   = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(60, 70)) : LW'($urandom_range(0, 12));
      end else begin
        start = 1'b0;
      end
      full  = ($urandom_range(0, 19) == 0) ? ROW'($urandom) : '0;
      empty = ($urandom_range(0, 19) == 0) ? ROW'($urandom) : '0;
      step();
    end
    start = 1'b0; full = '0; empty = '0;
    run_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
